// File: rtl/mwc_pkg.sv
// Shared types and constants for the mem_write_checker store-sequence checker.
// The optional watchdog is enabled with the MWC_TIMEOUT_EN macro.
package mwc_pkg;

    typedef enum logic [1:0] {
        MWC_LOAD = 2'd0,
        MWC_RUN  = 2'd1,
        MWC_PASS = 2'd2,
        MWC_FAIL = 2'd3
    } mwc_state_e;

    localparam logic [1:0] MWC_F_NONE     = 2'd0;
    localparam logic [1:0] MWC_F_MISMATCH = 2'd1;
    localparam logic [1:0] MWC_F_TIMEOUT  = 2'd2;
    localparam logic [1:0] MWC_F_EMPTY    = 2'd3;

endpackage

// File: rtl/mwc_exp_table.sv
// Expected-write table: one synchronous write port and one asynchronous read port.
// Out-of-range reads return zero so the read mux never selects a missing entry.
module mwc_exp_table
    import mwc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [CW-1:0]     i_wr_idx,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [CW-1:0]     i_rd_idx,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [ADDR_W+DATA_W-1:0] r_mem [DEPTH];
    logic [IW-1:0]            w_wr_i;
    logic [IW-1:0]            w_rd_i;

    assign w_wr_i = i_wr_idx[IW-1:0];
    assign w_rd_i = i_rd_idx[IW-1:0];

    // Table write port; contents need no reset because pointers gate every use
    always_ff @(posedge clk) begin
        if (i_wr_en && (i_wr_idx < DEPTH_C)) begin
            r_mem[w_wr_i] <= {i_wr_addr, i_wr_data};
        end
    end

    // Asynchronous read of the entry currently awaited
    always_comb begin
        o_rd_addr = {ADDR_W{1'b0}};
        o_rd_data = {DATA_W{1'b0}};
        if (i_rd_idx < DEPTH_C) begin
            {o_rd_addr, o_rd_data} = r_mem[w_rd_i];
        end else begin
            o_rd_addr = {ADDR_W{1'b0}};
            o_rd_data = {DATA_W{1'b0}};
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Store-sequence checker for the multicycle MIPS bus: compares stores in order
// against a loaded table. Define MWC_TIMEOUT_EN to build the RUN watchdog.
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int IGN_BASE = 80,
    parameter int IGN_SIZE = 4,
    parameter int TIMEOUT  = 1000,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              start,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [CW-1:0]     match_cnt
);

    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   ONE_C   = CW'(1);
    localparam logic [ADDR_W:0] IGN_LO  = (ADDR_W + 1)'(IGN_BASE);
    localparam logic [ADDR_W:0] IGN_HI  = (ADDR_W + 1)'(IGN_BASE + IGN_SIZE);
    localparam logic            WIN_EN  = (IGN_SIZE != 32'sd0);

    mwc_state_e        r_state, w_state_nxt;
    logic [CW-1:0]     r_wr_ptr, w_wr_ptr_nxt;
    logic [CW-1:0]     r_rd_ptr, w_rd_ptr_nxt;
    logic [CW-1:0]     r_exp_cnt, w_exp_cnt_nxt;
    logic [CW-1:0]     r_match_cnt, w_match_cnt_nxt;
    logic [1:0]        r_fail_code, w_fail_code_nxt;
    logic [ADDR_W-1:0] r_fail_addr, w_fail_addr_nxt;
    logic [DATA_W-1:0] r_fail_data, w_fail_data_nxt;
    logic              r_ld_ready, r_done, r_pass, r_fail;
    logic              w_ld_acc, w_in_win, w_hit;
    logic [ADDR_W-1:0] w_exp_addr;
    logic [DATA_W-1:0] w_exp_data;

`ifdef MWC_TIMEOUT_EN
    localparam int              TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT - 1);
    logic [TW-1:0] r_timer, w_timer_nxt;
`endif

    assign w_ld_acc = (r_state == MWC_LOAD) && ld_valid && (r_wr_ptr < DEPTH_C);
    // Extra top bit keeps the window bounds from wrapping near the address limit
    assign w_in_win = WIN_EN && ({1'b0, dataadr} >= IGN_LO) && ({1'b0, dataadr} < IGN_HI);
    assign w_hit    = (dataadr == w_exp_addr) && (writedata == w_exp_data);

    mwc_exp_table #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CW     (CW)
    ) u_table (
        .clk       (clk),
        .i_wr_en   (w_ld_acc),
        .i_wr_idx  (r_wr_ptr),
        .i_wr_addr (ld_addr),
        .i_wr_data (ld_data),
        .i_rd_idx  (r_rd_ptr),
        .o_rd_addr (w_exp_addr),
        .o_rd_data (w_exp_data)
    );

    // Next-state logic: load, start, in-order compare and watchdog
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_ptr_nxt    = w_ld_acc ? (r_wr_ptr + ONE_C) : r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_exp_cnt_nxt   = r_exp_cnt;
        w_match_cnt_nxt = r_match_cnt;
        w_fail_code_nxt = r_fail_code;
        w_fail_addr_nxt = r_fail_addr;
        w_fail_data_nxt = r_fail_data;
`ifdef MWC_TIMEOUT_EN
        w_timer_nxt     = r_timer;
`endif
        case (r_state)
            MWC_LOAD: begin
                if (start) begin
                    // A load in the same cycle as start is already counted in w_wr_ptr_nxt
                    if (w_wr_ptr_nxt == {CW{1'b0}}) begin
                        w_state_nxt     = MWC_FAIL;
                        w_fail_code_nxt = MWC_F_EMPTY;
                    end else begin
                        w_state_nxt   = MWC_RUN;
                        w_exp_cnt_nxt = w_wr_ptr_nxt;
                        w_rd_ptr_nxt  = {CW{1'b0}};
`ifdef MWC_TIMEOUT_EN
                        w_timer_nxt   = {TW{1'b0}};
`endif
                    end
                end else begin
                    w_state_nxt = MWC_LOAD;
                end
            end
            MWC_RUN: begin
`ifdef MWC_TIMEOUT_EN
                w_timer_nxt = r_timer + TW'(1);
`endif
                if (memwrite && !w_in_win) begin
                    if (w_hit) begin
                        w_match_cnt_nxt = r_match_cnt + ONE_C;
                        w_rd_ptr_nxt    = r_rd_ptr + ONE_C;
                        if ((r_rd_ptr + ONE_C) == r_exp_cnt) begin
                            w_state_nxt = MWC_PASS;
                        end else begin
                            w_state_nxt = MWC_RUN;
                        end
                    end else begin
                        w_state_nxt     = MWC_FAIL;
                        w_fail_code_nxt = MWC_F_MISMATCH;
                        w_fail_addr_nxt = dataadr;
                        w_fail_data_nxt = writedata;
                    end
                end else begin
                    w_state_nxt = MWC_RUN;
                end
`ifdef MWC_TIMEOUT_EN
                // Only fires when the store decision above left us in RUN
                if ((w_state_nxt == MWC_RUN) && (r_timer == TMAX)) begin
                    w_state_nxt     = MWC_FAIL;
                    w_fail_code_nxt = MWC_F_TIMEOUT;
                    w_fail_addr_nxt = w_exp_addr;
                    w_fail_data_nxt = w_exp_data;
                end else begin
                    w_timer_nxt = w_timer_nxt;
                end
`endif
            end
            MWC_PASS: w_state_nxt = MWC_PASS;
            MWC_FAIL: w_state_nxt = MWC_FAIL;
            default:  w_state_nxt = MWC_LOAD;
        endcase
    end

    // State, pointers and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= MWC_LOAD;
            r_wr_ptr    <= {CW{1'b0}};
            r_rd_ptr    <= {CW{1'b0}};
            r_exp_cnt   <= {CW{1'b0}};
            r_match_cnt <= {CW{1'b0}};
            r_fail_code <= MWC_F_NONE;
            r_fail_addr <= {ADDR_W{1'b0}};
            r_fail_data <= {DATA_W{1'b0}};
            r_ld_ready  <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
`ifdef MWC_TIMEOUT_EN
            r_timer     <= {TW{1'b0}};
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_exp_cnt   <= w_exp_cnt_nxt;
            r_match_cnt <= w_match_cnt_nxt;
            r_fail_code <= w_fail_code_nxt;
            r_fail_addr <= w_fail_addr_nxt;
            r_fail_data <= w_fail_data_nxt;
            r_ld_ready  <= (w_state_nxt == MWC_LOAD) && (w_wr_ptr_nxt < DEPTH_C);
            r_done      <= (w_state_nxt == MWC_PASS) || (w_state_nxt == MWC_FAIL);
            r_pass      <= (w_state_nxt == MWC_PASS);
            r_fail      <= (w_state_nxt == MWC_FAIL);
`ifdef MWC_TIMEOUT_EN
            r_timer     <= w_timer_nxt;
`endif
        end
    end

    assign ld_ready  = r_ld_ready;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign fail_code = r_fail_code;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;
    assign match_cnt = r_match_cnt;

endmodule
